// File: rtl/conv_output_collector_if.sv
// Stream bundle between the pooling pipeline and the output collector:
// the per-kernel input valid vector with its parallel lanes, plus the
// serial valid/ready output toward the dense stage and the overflow flag.
interface conv_output_collector_if #(
  parameter int BitSize            = 8,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2
);
  logic [NumberOfK-1:0]                   in_valid;
  logic [ProcessingElements*BitSize-1:0]  in_data;
  logic                                   in_ready;
  logic                                   out_valid;
  logic [BitSize-1:0]                     out_data;
  logic                                   out_last;
  logic                                   out_ready;
  logic                                   overflow;

  // Producer/consumer side: drives the input stream, accepts the output stream
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, overflow
  );

  // Collector side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/conv_output_collector.sv
// Collects one pooled frame (NumberOfK feature maps of OutWidth x OutWidth)
// arriving on parallel lanes with a per-kernel valid vector, then replays it
// kernel-major as a single serial valid/ready stream with a last marker.
module conv_output_collector #(
  parameter int BitSize            = 8,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2,
  parameter int OutWidth           = 3
) (
  input logic                     clk,
  input logic                     res_n,
  conv_output_collector_if.slave  bus
);

  localparam int PIXELS = OutWidth * OutWidth;
  localparam int DEPTH  = NumberOfK * PIXELS;
  localparam int CNT_W  = $clog2(PIXELS + 1);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIXELS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXELS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt      [NumberOfK];
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     rd_nxt;
  logic [BitSize-1:0]   mem      [DEPTH];
  logic [BitSize-1:0]   lane     [ProcessingElements];
  logic [IDX_W-1:0]     wr_addr  [NumberOfK];
  logic [NumberOfK-1:0] wr_en;
  logic [NumberOfK-1:0] drop;
  logic                 frame_done;
  logic [BitSize-1:0]   head_data;

  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [BitSize-1:0]   out_data_r;
  logic                 out_last_r;
  logic                 overflow_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.overflow  = overflow_r;

  assign rd_nxt = rd_idx + IDX_W'(1);

  // Split the packed input bus into its lanes
  always_comb begin
    for (int p = 0; p < ProcessingElements; p++) begin
      lane[p] = bus.in_data[p*BitSize +: BitSize];
    end
  end

  // Per-kernel write enables, drop detection and frame-complete look-ahead
  always_comb begin
    frame_done = (state == COLLECT);
    for (int k = 0; k < NumberOfK; k++) begin
      wr_en[k]   = (state == COLLECT) && bus.in_valid[k] && (cnt[k] != CNT_FULL);
      drop[k]    = bus.in_valid[k] && ((state == DRAIN) || (cnt[k] == CNT_FULL));
      wr_addr[k] = IDX_W'(k * PIXELS) + IDX_W'(cnt[k]);
      // A kernel is complete after this edge if already full or taking its last value now
      if (!((cnt[k] == CNT_FULL) || (wr_en[k] && (cnt[k] == CNT_LAST)))) begin
        frame_done = 1'b0;
      end
    end
  end

  // First output element; bypasses the buffer when entry 0 is written on the completing edge
  always_comb begin
    head_data = mem[0];
    if (wr_en[0] && (cnt[0] == '0)) begin
      head_data = lane[0];
    end
  end

  // Frame buffer: every accepted value lands at k*Pixels + arrival order
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumberOfK; k++) begin
      if (wr_en[k]) begin
        mem[wr_addr[k]] <= lane[k % ProcessingElements];
      end
    end
  end

  // Collect/drain control with registered stream outputs and sticky overflow
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= COLLECT;
      rd_idx      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      overflow_r  <= 1'b0;
      for (int k = 0; k < NumberOfK; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      if (|drop) begin
        overflow_r <= 1'b1;
      end
      case (state)
        COLLECT: begin
          for (int k = 0; k < NumberOfK; k++) begin
            if (wr_en[k]) begin
              cnt[k] <= cnt[k] + CNT_W'(1);
            end
          end
          if (frame_done) begin
            state       <= DRAIN;
            rd_idx      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= head_data;
            out_last_r  <= (DEPTH == 1);
          end
        end
        DRAIN: begin
          if (out_valid_r && bus.out_ready) begin
            if (rd_idx == LAST_IDX) begin
              state       <= COLLECT;
              rd_idx      <= '0;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              for (int k = 0; k < NumberOfK; k++) begin
                cnt[k] <= '0;
              end
            end else begin
              rd_idx     <= rd_nxt;
              out_data_r <= mem[rd_nxt];
              out_last_r <= (rd_nxt == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
// Directed bench for conv_output_collector: frame capture, kernel-major
// replay, backpressure, simultaneous writes, overflow, async reset and
// back-to-back frames, against hand-computed expected streams.
module tb_conv_output_collector;

  localparam int BW = 8;
  localparam int NK = 8;
  localparam int PE = 2;
  localparam int OW = 3;
  localparam int NE = NK * OW * OW;

  logic clk;
  logic res_n;
  int   nchk;
  int   nerr;
  logic [7:0] expv [NE];

  conv_output_collector_if #(.BitSize(BW), .NumberOfK(NK), .ProcessingElements(PE)) bus ();

  conv_output_collector #(
    .BitSize(BW), .NumberOfK(NK), .ProcessingElements(PE), .OutWidth(OW)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One input beat; returns 1 time unit after the capturing edge
  task automatic drive(input logic [7:0] v, input logic [7:0] l0, input logic [7:0] l1);
    bus.in_valid = v;
    bus.in_data  = {l1, l0};
    @(posedge clk);
    #1;
    bus.in_valid = '0;
  endtask

  // Scenario-1 frame: group g=c%4 feeds kernels 2g,2g+1; optional extra value for kernel 3
  task automatic send_frame1(input int ncyc, input bit extra);
    for (int c = 0; c < ncyc; c++) begin
      if (extra && c == 34) drive(8'h08, 8'h00, 8'hEE);
      if (c == 35) begin
        chk("pre_last_out_valid", 32'(bus.out_valid), 32'd0);
        chk("pre_last_in_ready", 32'(bus.in_ready), 32'd1);
      end
      drive(8'h03 << (2 * (c % 4)), 8'(c), 8'(c + 100));
    end
  endtask

  task automatic send_frame3();
    for (int n = 0; n < 9; n++) begin
      if (n == 8) chk("s3_pre_last_valid", 32'(bus.out_valid), 32'd0);
      drive(8'hFF, 8'(8'h11 * n), 8'(8'h22 * n));
    end
  endtask

  task automatic fill_exp1();
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 9; i++)
        expv[k*9+i] = 8'(((k % 2) ? 100 : 0) + k / 2 + 4 * i);
  endtask

  task automatic fill_exp3();
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 9; i++)
        expv[k*9+i] = (k % 2) ? 8'(34 * i) : 8'(17 * i);
  endtask

  task automatic after_frame(input string tag);
    chk({tag, "_out_valid_rise"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
  endtask

  // Accept up to nmax elements; mode 1 toggles out_ready 1,0,0,1 and checks hold stability
  task automatic drain(input string tag, input int mode, input int nmax);
    int n = 0;
    int cyc = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    logic pstall = 1'b0;
    while (n < nmax && cyc < 2000) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (pstall) begin
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_data"}, 32'(bus.out_data), 32'(pd));
        chk({tag, "_hold_last"}, 32'(bus.out_last), 32'(pl));
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          chk({tag, "_data"}, 32'(bus.out_data), 32'(expv[n]));
          chk({tag, "_last"}, 32'(bus.out_last), (n == NE - 1) ? 32'd1 : 32'd0);
          n++;
        end
        pstall = !bus.out_ready;
        pd = bus.out_data;
        pl = bus.out_last;
      end else begin
        pstall = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk({tag, "_count"}, 32'(n), 32'(nmax));
    if (nmax == NE) begin
      chk({tag, "_end_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_end_in_ready"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    res_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
  endtask

  // Asynchronous reset pulse between edges; outputs checked before any edge
  task automatic async_reset(input string tag);
    res_n = 1'b0;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    #1;
    res_n = 1'b1;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    do_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // Single frame without backpressure
    fill_exp1();
    send_frame1(36, 1'b0);
    after_frame("s1");
    drain("s1", 0, NE);
    chk("s1_overflow", 32'(bus.overflow), 32'd0);

    // Backpressure; frame starts as soon as in_ready returns
    send_frame1(36, 1'b0);
    after_frame("s2");
    drain("s2", 1, NE);

    // All kernels written each cycle, lanes shared
    fill_exp3();
    send_frame3();
    after_frame("s3");
    drain("s3", 0, NE);

    // Back-to-back frames of different contents
    fill_exp1();
    send_frame1(36, 1'b0);
    after_frame("s6a");
    drain("s6a", 0, NE);
    fill_exp3();
    send_frame3();
    after_frame("s6b");
    drain("s6b", 0, NE);
    chk("s6_overflow", 32'(bus.overflow), 32'd0);

    // Overflow from a tenth kernel-3 value during collect
    do_reset();
    fill_exp1();
    send_frame1(36, 1'b1);
    after_frame("s4a");
    chk("s4a_overflow", 32'(bus.overflow), 32'd1);
    drain("s4a", 0, NE);
    chk("s4a_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Overflow from a value arriving during drain
    do_reset();
    send_frame1(36, 1'b0);
    after_frame("s4b");
    chk("s4b_overflow_pre", 32'(bus.overflow), 32'd0);
    drive(8'h01, 8'hEE, 8'hEE);
    chk("s4b_overflow", 32'(bus.overflow), 32'd1);
    chk("s4b_head_kept", 32'(bus.out_data), 32'(expv[0]));
    drain("s4b", 1, NE);
    chk("s4b_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Reset mid-collect and mid-drain, then clean frames
    do_reset();
    send_frame1(20, 1'b0);
    async_reset("s5_collect_rst");
    send_frame1(36, 1'b0);
    after_frame("s5a");
    drain("s5a", 0, 10);
    chk("s5_mid_drain_valid", 32'(bus.out_valid), 32'd1);
    async_reset("s5_drain_rst");
    send_frame1(36, 1'b0);
    after_frame("s5b");
    drain("s5b", 0, NE);
    chk("s5_overflow", 32'(bus.overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_output_collector.md
Name: conv_output_collector

Overview:
- Receives the pooled feature-map stream produced by the conv/pooling pipeline: a per-kernel valid vector plus ProcessingElements parallel lanes.
- Stores one complete frame of NumberOfK x OutWidth x OutWidth values.
- Replays the frame as a single serial valid/ready stream, kernel-major, for the dense stage.
- This is the receive-side counterpart of the pixel streamer that feeds conv_pooling_top.

Parameters:
BitSize, 8, width of one feature value
NumberOfK, 8, number of kernels (feature maps) on the input valid vector
ProcessingElements, 2, number of parallel data lanes; NumberOfK % ProcessingElements == 0
OutWidth, 3, feature-map side length; Pixels = OutWidth*OutWidth per kernel

Ports:
clk  in  1  clock, rising edge
res_n  in  1  reset, asynchronous, active-low
in_valid  in  NumberOfK  bit k high = value for kernel k is present on lane k % ProcessingElements
in_data  in  ProcessingElements*BitSize  lane p = bits [p*BitSize +: BitSize]
in_ready  out  1  high while in COLLECT
out_valid  out  1  serial output element valid
out_data  out  BitSize  serial output element
out_last  out  1  high with the final element of a frame
out_ready  in  1  downstream accept
overflow  out  1  sticky drop flag

Behaviour:
Reset (async, res_n=0):
- State is COLLECT.
- All per-kernel counters are 0 and the read index is 0.
- Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, overflow=0.
- Buffer contents are don't-care.
- Reset asserted mid-frame or mid-drain aborts the frame. There is no partial output after release.

Storage:
- Buffer has NumberOfK*Pixels entries.
- Address = k*Pixels + cnt[k], where cnt[k] is a ceil(log2(Pixels+1))-bit counter for kernel k.

COLLECT:
- On each rising edge, for every k with in_valid[k]=1 and cnt[k] < Pixels:
  - buf[k*Pixels+cnt[k]] <= lane (k % ProcessingElements);
  - cnt[k] increments.
- Several kernels may be written in the same cycle, including kernels that share a lane (all receive that lane's value).
- If in_valid[k]=1 and cnt[k]==Pixels, the value is dropped and overflow is set.
- Frame completes on the edge where the last counter reaches Pixels, i.e. all cnt[k]==Pixels after the update.
- The next state is DRAIN, so out_valid rises exactly 1 cycle after the final input edge.

DRAIN:
- in_ready=0.
- out_valid=1.
- out_data = buf[rd_idx], registered and presented in the same cycle that out_valid is high.
- out_last = (rd_idx == NumberOfK*Pixels-1).
- On an edge with out_valid & out_ready, rd_idx increments.
- If that edge accepts the last element:
  - rd_idx returns to 0 and all cnt clear;
  - state returns to COLLECT, with out_valid=0 on the next cycle.
- With out_ready=0, out_data, out_valid and out_last hold stable (AXI-style; no retraction).
- Any in_valid bit high during DRAIN drops the value and sets overflow.

Order and flags:
- Output order is kernel 0 pixels 0..Pixels-1, then kernel 1, and so on: element index = k*Pixels + arrival order.
- overflow is cleared only by reset.
- No arithmetic is performed; values pass through bit-exact.

Test Plan:
1. Single frame, no backpressure (defaults):
   - Stimulus: 36 input cycles. Groups cycle through lanes: cycle c asserts in_valid bits {2g, 2g+1} with g=c%4, lane0=c, lane1=c+100, until every kernel has 9 values.
   - Response: out_valid rises 1 cycle after the last input; 72 elements stream in kernel-major order. The kernel 0 sequence is 0,4,8,...,32; the kernel 1 sequence is 100,104,...,132. out_last is high only on element 71. in_ready returns to 1 the cycle after.
2. Backpressure:
   - Stimulus: same frame as scenario 1, with out_ready toggling 1,0,0,1.
   - Response: out_data and out_valid are stable during every low out_ready cycle; no element is lost or duplicated; 72 handshakes total.
3. Simultaneous writes:
   - Stimulus: all 8 in_valid bits high for 9 cycles, lane0=0x11*n, lane1=0x22*n.
   - Response: frame completes after 9 cycles. Even kernels read 0x00,0x11,...,0x88. Odd kernels read 0x00,0x22,...,0x10 (8-bit wrap).
4. Overflow:
   - Stimulus: kernel 3 receives a 10th value before the other kernels finish; separately, a value arrives during DRAIN.
   - Response: both extra values are dropped, overflow=1 and sticky, and the frame contents are unchanged.
5. Reset mid-operation:
   - Stimulus: res_n pulsed low during COLLECT after 20 inputs, and again during DRAIN after 10 outputs.
   - Response: outputs go to their reset values immediately (async). A full clean frame afterwards reproduces scenario 1 exactly.
6. Back-to-back frames:
   - Stimulus: a second frame starts on the cycle in_ready returns to 1.
   - Response: the second frame is captured completely and drains with the correct values; overflow stays 0.
